bram_frame_reader: RTL
======================

Name: bram_frame_reader

Overview:
- Read-side initiator for the single-port pixel BRAM. On a start pulse it walks one IMG_WIDTH x IMG_HEIGHT frame from BASE_ADDR upward and issues one BRAM read per pixel.
- It absorbs the BRAM's 1-cycle registered read latency in a 2-entry output buffer and streams the pixels out over a valid/ready interface with frame and line markers.
- It sits between the frame BRAM and downstream consumers: display, UART dump, filter pipeline.

Parameters:
- RAM_WIDTH, 24, pixel width (24 RGB or 8 gray); matches the BRAM data width.
- RAM_ADDR_BITS, 16, BRAM address width.
- IMG_WIDTH, 220, pixels per line (>=1).
- IMG_HEIGHT, 220, lines per frame (>=1).
- BASE_ADDR, 0, address of pixel (0,0).

Ports:
- clock  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a frame; sampled only when busy=0.
- busy  out  1  high from the cycle after start is accepted until the done cycle.
- done  out  1  one-cycle pulse after the final pixel is accepted downstream.
- ram_enable  out  1  BRAM enable; high exactly in read-issue cycles.
- write_enable  out  1  constant 0.
- address  out  RAM_ADDR_BITS  BRAM read address.
- ram_data  in  RAM_WIDTH  BRAM output_data; valid the cycle after the read issue.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accept.
- m_data  out  RAM_WIDTH  pixel.
- m_sof  out  1  beat is pixel (0,0).
- m_eol  out  1  beat is the last pixel of a line.
- m_last  out  1  beat is the final pixel of the frame.

Behaviour:
- Reset values: busy=0, done=0, ram_enable=0, address=BASE_ADDR, m_valid=0, m_data=0, m_sof=0, m_eol=0, m_last=0. The buffer is emptied and any in-flight read is discarded.
- Elaboration check: BASE_ADDR + IMG_WIDTH*IMG_HEIGHT - 1 <= 2^RAM_ADDR_BITS - 1. If violated, elaboration fails with $error. The address never wraps.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: start=1 moves to READ.
  - READ: issues reads. After the read for pixel N-1 is issued (N = IMG_WIDTH*IMG_HEIGHT), moves to DRAIN.
  - DRAIN: waits until the in-flight read has landed and the buffer is empty, i.e. the m_last beat has handshaken. Then moves to DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- start is ignored in READ, DRAIN and DONE.
- Read issue rule: in cycle t, issue a read (ram_enable=1, address=next pixel) iff state is READ and (buffer occupancy + in-flight reads - pop in cycle t) < 2.
  - A pop is m_valid & m_ready.
  - There are at most 2 pixels in flight plus buffered at any time.
  - No BRAM data is ever dropped.
- Capture: data from a read issued in cycle t is written into the buffer at the end of cycle t+1, together with its sof/eol/last tags, which are computed at issue time.
- Latency: start sampled at edge E0 → first read in the cycle after E0 → m_valid=1 after edge E2, i.e. 2 cycles after start is sampled.
- Throughput: with m_ready held at 1, one beat per cycle with no bubbles.
- Address generation: incremental. Column counter 0..IMG_WIDTH-1 and row counter 0..IMG_HEIGHT-1; address increments by 1 per issued read.
  - m_eol marks col = IMG_WIDTH-1.
  - m_sof marks row 0, col 0.
  - m_last marks the final pixel; it is also an eol beat.
  - With IMG_WIDTH=1, every beat has m_eol=1.
- Output handshake: m_data and the tags are stable while m_valid=1 and m_ready=0. m_valid never drops without a handshake.
- Simultaneous push and pop on a full buffer is legal; occupancy is unchanged.
- Reset mid-frame: the next cycle is IDLE with all outputs at reset values. A partially streamed frame is abandoned and done is not pulsed.

Optional Feature:
- Macro: BRAM_FRAME_READER_CONTINUOUS_EN.
- Defined:
  - If start=1 in the cycle the read for pixel N-1 is issued, the reader stays in READ and the next issue cycle reads BASE_ADDR with the sof tag. There is no bubble between frames.
  - done pulses for one cycle when each frame's m_last beat handshakes; busy stays 1.
  - If start=0 in that cycle, the reader follows the normal DRAIN/DONE flow.
- Undefined: single-frame only; start is ignored unless the reader is in IDLE.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=3, BASE_ADDR=16, BRAM preloaded with data = address, m_ready=1, start pulse → 12 consecutive beats with data 16..27.
  - First m_valid 2 cycles after start.
  - m_sof on beat 0; m_eol on beats 3, 7, 11; m_last on beat 11.
  - done is high for one cycle, the cycle after beat 11.
- Same frame, m_ready low for 6 cycles starting at beat 2 → exactly 2 reads outstanding and ram_enable=0 during the stall. Beat 2's data is held stable; the sequence resumes 16..27 with no loss or duplication.
- Random 50% m_ready over a full 220x220 frame → 48400 beats in address order, one m_last, one done.
- start asserted again while in READ and DRAIN → ignored. After done, start in IDLE → a second identical frame.
- reset asserted at beat 5 → next cycle m_valid=0, busy=0, ram_enable=0, no done. A fresh start reproduces the full frame from BASE_ADDR.
- With BRAM_FRAME_READER_CONTINUOUS_EN and start held at 1, m_ready=1 → back-to-back frames, each beat 12 of 12 followed immediately by an m_sof beat with data 16. done pulses once per frame and busy stays 1.

Source files
------------

// File: rtl/bram_frame_reader.sv
// bram_frame_reader: walks one IMG_WIDTH x IMG_HEIGHT frame out of a single-port
// pixel BRAM starting at BASE_ADDR. It absorbs the 1-cycle registered read latency
// in a 2-entry buffer and streams the pixels over valid/ready with sof/eol/last tags.
// Optional build macro: BRAM_FRAME_READER_CONTINUOUS_EN (back-to-back frames while start is held).
module bram_frame_reader #(
    parameter int unsigned RAM_WIDTH     = 24,
    parameter int unsigned RAM_ADDR_BITS = 16,
    parameter int unsigned IMG_WIDTH     = 220,
    parameter int unsigned IMG_HEIGHT    = 220,
    parameter int unsigned BASE_ADDR     = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     ram_enable,
    output logic                     write_enable,
    output logic [RAM_ADDR_BITS-1:0] address,
    input  logic [RAM_WIDTH-1:0]     ram_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [RAM_WIDTH-1:0]     m_data,
    output logic                     m_sof,
    output logic                     m_eol,
    output logic                     m_last
);

    localparam int unsigned COL_BITS = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int unsigned ROW_BITS = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam longint unsigned LAST_ADDR =
        64'(BASE_ADDR) + 64'(IMG_WIDTH) * 64'(IMG_HEIGHT) - 64'd1;
    localparam longint unsigned ADDR_MAX = (64'd1 << RAM_ADDR_BITS) - 64'd1;

    // The frame must fit in the address space; the address counter never wraps.
    generate
        if (LAST_ADDR > ADDR_MAX) begin : g_addr_range_check
            $error("bram_frame_reader: frame does not fit in RAM_ADDR_BITS address space");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [COL_BITS-1:0] col;
    logic [ROW_BITS-1:0] row;
    logic                col_end;
    logic                row_end;
    logic                pix_last;
    logic                issue;
    logic                pop;
    logic [1:0]          occ_after;

    // Read issued last cycle; its data is on ram_data this cycle.
    logic pend_v;
    logic pend_sof;
    logic pend_eol;
    logic pend_last;

    // Second buffer entry behind the output register.
    logic                 skid_v;
    logic [RAM_WIDTH-1:0] skid_data;
    logic                 skid_sof;
    logic                 skid_eol;
    logic                 skid_last;

    assign write_enable = 1'b0;
    assign ram_enable   = issue;
    assign busy         = (state == READ) || (state == DRAIN);

    // Occupancy after this cycle's pop, counting the in-flight read, plus position decode.
    always_comb begin
        pop       = m_valid & m_ready;
        occ_after = 2'(m_valid) + 2'(skid_v) + 2'(pend_v) - 2'(pop);
        col_end   = (col == COL_BITS'(IMG_WIDTH - 1));
        row_end   = (row == ROW_BITS'(IMG_HEIGHT - 1));
        pix_last  = col_end && row_end;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and read-issue decision.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (occ_after < 2'd2) begin
                    issue = 1'b1;
                    if (pix_last) begin
`ifdef BRAM_FRAME_READER_CONTINUOUS_EN
                        if (!start) begin
                            state_next = DRAIN;
                        end
`else
                        state_next = DRAIN;
`endif
                    end
                end
            end
            DRAIN: begin
                if (occ_after == 2'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Column/row/address counters; rewind to pixel (0,0) after the final issue.
    always_ff @(posedge clock) begin
        if (reset) begin
            col     <= '0;
            row     <= '0;
            address <= RAM_ADDR_BITS'(BASE_ADDR);
        end else if (issue) begin
            if (pix_last) begin
                col     <= '0;
                row     <= '0;
                address <= RAM_ADDR_BITS'(BASE_ADDR);
            end else begin
                address <= address + RAM_ADDR_BITS'(1);
                if (col_end) begin
                    col <= '0;
                    row <= row + ROW_BITS'(1);
                end else begin
                    col <= col + COL_BITS'(1);
                end
            end
        end
    end

    // Track the in-flight read and the tags computed at issue time.
    always_ff @(posedge clock) begin
        if (reset) begin
            pend_v    <= 1'b0;
            pend_sof  <= 1'b0;
            pend_eol  <= 1'b0;
            pend_last <= 1'b0;
        end else begin
            pend_v <= issue;
            if (issue) begin
                pend_sof  <= (col == '0) && (row == '0);
                pend_eol  <= col_end;
                pend_last <= pix_last;
            end
        end
    end

    // Two-entry output buffer: output register as head, skid entry behind it.
    always_ff @(posedge clock) begin
        if (reset) begin
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_sof     <= 1'b0;
            m_eol     <= 1'b0;
            m_last    <= 1'b0;
            skid_v    <= 1'b0;
            skid_data <= '0;
            skid_sof  <= 1'b0;
            skid_eol  <= 1'b0;
            skid_last <= 1'b0;
        end else if (!m_valid || pop) begin
            if (skid_v) begin
                m_valid   <= 1'b1;
                m_data    <= skid_data;
                m_sof     <= skid_sof;
                m_eol     <= skid_eol;
                m_last    <= skid_last;
                skid_v    <= pend_v;
                skid_data <= ram_data;
                skid_sof  <= pend_sof;
                skid_eol  <= pend_eol;
                skid_last <= pend_last;
            end else if (pend_v) begin
                m_valid <= 1'b1;
                m_data  <= ram_data;
                m_sof   <= pend_sof;
                m_eol   <= pend_eol;
                m_last  <= pend_last;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (pend_v) begin
            skid_v    <= 1'b1;
            skid_data <= ram_data;
            skid_sof  <= pend_sof;
            skid_eol  <= pend_eol;
            skid_last <= pend_last;
        end
    end

    // One-cycle done pulse after the final beat of a frame is accepted.
    always_ff @(posedge clock) begin
        if (reset) begin
            done <= 1'b0;
        end else begin
            done <= pop && m_last;
        end
    end

endmodule
